// File: rtl/ddr_app_bridge_if.sv
// DDR controller user ("app") port bundle between the bridge and the controller.
// The master modport is the bridge side, the slave modport is the controller side.
interface ddr_app_bridge_if #(
   parameter int ADDR_W = 27,
   parameter int DATA_W = 128
);
   logic [ADDR_W-1:0]   app_addr;
   logic [2:0]          app_cmd;
   logic                app_en;
   logic                app_rdy;
   logic [DATA_W-1:0]   app_wdf_data;
   logic                app_wdf_wren;
   logic                app_wdf_end;
   logic [DATA_W/8-1:0] app_wdf_mask;
   logic                app_wdf_rdy;
   logic [DATA_W-1:0]   app_rd_data;
   logic                app_rd_data_valid;

   modport master (
      output app_addr, app_cmd, app_en,
      output app_wdf_data, app_wdf_wren,
      output app_wdf_end, app_wdf_mask,
      input  app_rdy, app_wdf_rdy,
      input  app_rd_data, app_rd_data_valid
   );

   modport slave (
      input  app_addr, app_cmd, app_en,
      input  app_wdf_data, app_wdf_wren,
      input  app_wdf_end, app_wdf_mask,
      output app_rdy, app_wdf_rdy,
      output app_rd_data, app_rd_data_valid
   );
endinterface

// File: rtl/ddr_app_bridge.sv
// Data-cache line read/write pulses to DDR app interface, one pending of each.
// Define DDR_APP_BRIDGE_ALIGN_EN to line-align app_addr (strip word offset).
module ddr_app_bridge #(
   parameter int ADDR_W = 27,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_en,
   output logic              rd_fin,
   output logic [DATA_W-1:0] rd_data,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   output logic              wr_fin,
   output logic              ovf,
   input  logic              calib_done,
   ddr_app_bridge_if.master  app
);

   typedef enum logic [1:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WR
   } state_t;

   state_t            state, state_n;
   logic              rd_pend, wr_pend;
   logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              cmd_done, dat_done;
   logic              cmd_done_n, dat_done_n;
   logic              cmd_en, dat_en;
   logic              rd_clr, wr_clr;
   logic              rd_fin_n, wr_fin_n;
   logic              ld_rd, ld_wr;
   logic              rd_busy, wr_busy;

   function automatic logic [ADDR_W-1:0] map_addr(
      input logic [ADDR_W-1:0] a
   );
`ifdef DDR_APP_BRIDGE_ALIGN_EN
      return {a[ADDR_W-1:4], 4'b0000};
`else
      return a;
`endif
   endfunction

   // a pending flag being cleared this cycle can accept a new pulse
   assign rd_busy = rd_pend & ~rd_clr;
   assign wr_busy = wr_pend & ~wr_clr;

   assign app.app_en       = cmd_en;
   assign app.app_wdf_wren = dat_en;
   assign app.app_wdf_end  = dat_en;
   assign app.app_wdf_mask = '0;

   always_comb begin
      state_n    = state;
      cmd_en     = 1'b0;
      dat_en     = 1'b0;
      cmd_done_n = cmd_done;
      dat_done_n = dat_done;
      rd_clr     = 1'b0;
      wr_clr     = 1'b0;
      rd_fin_n   = 1'b0;
      wr_fin_n   = 1'b0;
      ld_rd      = 1'b0;
      ld_wr      = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_done_n = 1'b0;
            dat_done_n = 1'b0;
            if (calib_done) begin
               if (wr_pend) begin
                  state_n = WR;
                  ld_wr   = 1'b1;
               end else if (rd_pend) begin
                  state_n = RD_CMD;
                  ld_rd   = 1'b1;
               end
            end
         end
         RD_CMD: begin
            cmd_en = 1'b1;
            if (app.app_rdy) begin
               rd_clr  = 1'b1;
               state_n = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (app.app_rd_data_valid) begin
               rd_fin_n = 1'b1;
               state_n  = IDLE;
            end
         end
         WR: begin
            cmd_en     = ~cmd_done;
            dat_en     = ~dat_done;
            cmd_done_n = cmd_done | (cmd_en & app.app_rdy);
            dat_done_n = dat_done | (dat_en & app.app_wdf_rdy);
            if (cmd_done_n && dat_done_n) begin
               wr_clr   = 1'b1;
               wr_fin_n = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state            <= IDLE;
         rd_pend          <= 1'b0;
         wr_pend          <= 1'b0;
         cmd_done         <= 1'b0;
         dat_done         <= 1'b0;
         rd_fin           <= 1'b0;
         wr_fin           <= 1'b0;
         ovf              <= 1'b0;
         rd_data          <= '0;
         app.app_addr     <= '0;
         app.app_cmd      <= 3'b001;
         app.app_wdf_data <= '0;
      end else begin
         state    <= state_n;
         cmd_done <= cmd_done_n;
         dat_done <= dat_done_n;
         rd_fin   <= rd_fin_n;
         wr_fin   <= wr_fin_n;
         if ((rd_en && rd_busy) || (wr_en && wr_busy))
            ovf <= 1'b1;
         if (rd_en && !rd_busy)
            rd_pend <= 1'b1;
         else if (rd_clr)
            rd_pend <= 1'b0;
         if (wr_en && !wr_busy)
            wr_pend <= 1'b1;
         else if (wr_clr)
            wr_pend <= 1'b0;
         if (rd_fin_n)
            rd_data <= app.app_rd_data;
         if (ld_rd) begin
            app.app_addr <= map_addr(rd_addr_q);
            app.app_cmd  <= 3'b001;
         end
         if (ld_wr) begin
            app.app_addr     <= map_addr(wr_addr_q);
            app.app_cmd      <= 3'b000;
            app.app_wdf_data <= wr_data_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en && !rd_busy)
         rd_addr_q <= rd_addr;
      if (wr_en && !wr_busy) begin
         wr_addr_q <= wr_addr;
         wr_data_q <= wr_data;
      end
   end

endmodule

// File: tb/tb_ddr_app_bridge.sv
// Directed bench for ddr_app_bridge: reads, writes, priority, calib gating,
// overflow and reset during an outstanding read.
module tb_ddr_app_bridge;
   localparam int AW = 27;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_en = 1'b0;
   logic          rd_fin;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_en = 1'b0;
   logic          wr_fin;
   logic          ovf;
   logic          calib_done = 1'b1;

   int total = 0;
   int bad = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int both_cnt = 0;
   int r0, w0;

   always #5 clk = ~clk;

   ddr_app_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) app ();

   ddr_app_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk),
      .rstn(rstn),
      .rd_addr(rd_addr),
      .rd_en(rd_en),
      .rd_fin(rd_fin),
      .rd_data(rd_data),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_en(wr_en),
      .wr_fin(wr_fin),
      .ovf(ovf),
      .calib_done(calib_done),
      .app(app)
   );

   always @(posedge clk) begin
      if (rd_fin) rd_cnt++;
      if (wr_fin) wr_cnt++;
      if (rd_fin && wr_fin) both_cnt++;
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] ea(input logic [AW-1:0] a);
`ifdef DDR_APP_BRIDGE_ALIGN_EN
      return {a[AW-1:4], 4'b0000};
`else
      return a;
`endif
   endfunction

   initial begin
      app.app_rdy = 1'b0;
      app.app_wdf_rdy = 1'b0;
      app.app_rd_data = '0;
      app.app_rd_data_valid = 1'b0;
      tick(3);
      chk("rst_rd_fin", rd_fin, 0);
      chk("rst_wr_fin", wr_fin, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_app_en", app.app_en, 0);
      chk("rst_wren", app.app_wdf_wren, 0);
      chk("rst_wend", app.app_wdf_end, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_addr", app.app_addr, 0);
      chk("rst_cmd", app.app_cmd, 3'b001);
      chk("rst_wdata", app.app_wdf_data, 0);
      chk("rst_mask", app.app_wdf_mask, 0);
      rstn = 1'b1;
      tick();

      // read, app_rdy immediate, data 3 cycles after handshake
      rd_addr = 27'h0001234;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("t1_en_t1", app.app_en, 0);
      tick();
      chk("t1_en_t2", app.app_en, 1);
      chk("t1_cmd", app.app_cmd, 3'b001);
      chk("t1_addr", app.app_addr, ea(27'h0001234));
      app.app_rdy = 1'b1;
      tick();
      app.app_rdy = 1'b0;
      chk("t1_en_drop", app.app_en, 0);
      tick(2);
      app.app_rd_data = 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF;
      app.app_rd_data_valid = 1'b1;
      chk("t1_fin_early", rd_fin, 0);
      tick();
      app.app_rd_data_valid = 1'b0;
      chk("t1_fin", rd_fin, 1);
      chk("t1_data", rd_data, 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF);
      tick();
      chk("t1_fin_pulse", rd_fin, 0);

      // write, data accepted before command
      app.app_wdf_rdy = 1'b1;
      wr_addr = 27'h0000ABC;
      wr_data = 128'h11111111_22222222_33333333_44444444;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      chk("t2_en_t1", app.app_en, 0);
      tick();
      chk("t2_en", app.app_en, 1);
      chk("t2_wren", app.app_wdf_wren, 1);
      chk("t2_wend", app.app_wdf_end, 1);
      chk("t2_cmd", app.app_cmd, 3'b000);
      chk("t2_addr", app.app_addr, ea(27'h0000ABC));
      chk("t2_wdata", app.app_wdf_data,
          128'h11111111_22222222_33333333_44444444);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_en_hold", app.app_en, 1);
         chk("t2_wren_drop", app.app_wdf_wren, 0);
         chk("t2_wfin_early", wr_fin, 0);
      end
      tick();
      chk("t2_en_last", app.app_en, 1);
      app.app_rdy = 1'b1;
      tick();
      app.app_rdy = 1'b0;
      app.app_wdf_rdy = 1'b0;
      chk("t2_wfin", wr_fin, 1);
      chk("t2_en_off", app.app_en, 0);
      tick();
      chk("t2_wfin_pulse", wr_fin, 0);

      // simultaneous read and write: write first
      r0 = rd_cnt;
      w0 = wr_cnt;
      app.app_rdy = 1'b1;
      app.app_wdf_rdy = 1'b1;
      rd_addr = 27'h0000100;
      wr_addr = 27'h0000200;
      wr_data = 128'h5555;
      rd_en = 1'b1;
      wr_en = 1'b1;
      tick();
      rd_en = 1'b0;
      wr_en = 1'b0;
      tick();
      chk("t3_wr_en", app.app_en, 1);
      chk("t3_wr_cmd", app.app_cmd, 3'b000);
      chk("t3_wr_wren", app.app_wdf_wren, 1);
      chk("t3_wr_addr", app.app_addr, ea(27'h0000200));
      tick();
      chk("t3_wfin", wr_fin, 1);
      chk("t3_en_gap", app.app_en, 0);
      tick();
      chk("t3_rd_en", app.app_en, 1);
      chk("t3_rd_cmd", app.app_cmd, 3'b001);
      chk("t3_rd_addr", app.app_addr, ea(27'h0000100));
      tick();
      app.app_rdy = 1'b0;
      app.app_wdf_rdy = 1'b0;
      chk("t3_en_off", app.app_en, 0);
      app.app_rd_data = 128'h77;
      app.app_rd_data_valid = 1'b1;
      tick();
      app.app_rd_data_valid = 1'b0;
      chk("t3_rfin", rd_fin, 1);
      chk("t3_rdata", rd_data, 128'h77);
      tick();
      chk("t3_rd_count", rd_cnt - r0, 1);
      chk("t3_wr_count", wr_cnt - w0, 1);

      // calibration gating
      calib_done = 1'b0;
      rd_addr = 27'h0000040;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t4_no_en", app.app_en, 0);
         tick();
      end
      calib_done = 1'b1;
      app.app_rdy = 1'b1;
      chk("t4_no_en_c", app.app_en, 0);
      tick();
      chk("t4_en", app.app_en, 1);
      chk("t4_addr", app.app_addr, ea(27'h0000040));
      tick();
      app.app_rdy = 1'b0;
      app.app_rd_data = 128'h4242;
      app.app_rd_data_valid = 1'b1;
      tick();
      app.app_rd_data_valid = 1'b0;
      chk("t4_rfin", rd_fin, 1);
      chk("t4_rdata", rd_data, 128'h4242);
      tick();

      // overflow on second read while pending
      r0 = rd_cnt;
      rd_addr = 27'h0000300;
      rd_en = 1'b1;
      tick();
      rd_addr = 27'h0000400;
      chk("t5_ovf_pre", ovf, 0);
      tick();
      rd_en = 1'b0;
      chk("t5_ovf", ovf, 1);
      chk("t5_en", app.app_en, 1);
      chk("t5_addr", app.app_addr, ea(27'h0000300));
      app.app_rdy = 1'b1;
      tick();
      app.app_rdy = 1'b0;
      app.app_rd_data = 128'h99;
      app.app_rd_data_valid = 1'b1;
      tick();
      app.app_rd_data_valid = 1'b0;
      chk("t5_rfin", rd_fin, 1);
      tick();
      chk("t5_no_second", app.app_en, 0);
      chk("t5_ovf_sticky", ovf, 1);
      tick(2);
      chk("t5_rd_count", rd_cnt - r0, 1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("t5_ovf_rst", ovf, 0);
      tick();

      // reset while waiting for read data
      r0 = rd_cnt;
      app.app_rdy = 1'b1;
      rd_addr = 27'h0000500;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
      chk("t6_en", app.app_en, 1);
      tick();
      app.app_rdy = 1'b0;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("t6_rdata_rst", rd_data, 0);
      app.app_rd_data = 128'hBAD;
      app.app_rd_data_valid = 1'b1;
      tick();
      app.app_rd_data_valid = 1'b0;
      chk("t6_no_fin", rd_fin, 0);
      tick();
      chk("t6_no_fin2", rd_fin, 0);
      chk("t6_idle", app.app_en, 0);
      chk("t6_rd_count", rd_cnt - r0, 0);
      app.app_rdy = 1'b1;
      rd_addr = 27'h0000600;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
      chk("t6_en2", app.app_en, 1);
      chk("t6_addr2", app.app_addr, ea(27'h0000600));
      tick();
      app.app_rdy = 1'b0;
      app.app_rd_data = 128'h600D;
      app.app_rd_data_valid = 1'b1;
      tick();
      app.app_rd_data_valid = 1'b0;
      chk("t6_rfin", rd_fin, 1);
      chk("t6_rdata", rd_data, 128'h600D);
      tick();
      chk("fin_overlap", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
